// File: rtl/fpu_pkg.sv
// Shared constants for the FPU operand scheduler: state encoding and
// IEEE-754 single-precision field widths / canned abort value.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    localparam logic [31:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/fpu_operand_sched_if.sv
// Bundle of requester, FPU-side and result handshake signals around the
// operand scheduler.
interface fpu_operand_sched_if #(
    parameter int DATA_W = 32
);
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [DATA_W-1:0] in1_data;
    logic              mux_sel;
    logic [DATA_W-1:0] op_data;
    logic              fpu_start;
    logic              fpu_done;
    logic [DATA_W-1:0] fpu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_id;
    logic              out_err;
    logic              busy;

    modport sched (
        input  in0_valid, in0_data, in1_valid, in1_data,
               fpu_done, fpu_result, out_ready,
        output in0_ready, in1_ready, mux_sel, op_data, fpu_start,
               out_valid, out_data, out_id, out_err, busy
    );

    modport tb (
        output in0_valid, in0_data, in1_valid, in1_data,
               fpu_done, fpu_result, out_ready,
        input  in0_ready, in1_ready, mux_sel, op_data, fpu_start,
               out_valid, out_data, out_id, out_err, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: ptr_i picks the winner only when both request.
module rr_arbiter_2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic gnt_idx_o,
    output logic gnt_vld_o
);

    assign gnt_vld_o = req0_i | req1_i;
    assign gnt_idx_o = (req0_i & req1_i) ? ptr_i : req1_i;

endmodule

// File: rtl/fpu_operand_sched.sv
// Shares one FPU operand path between two requesters: arbitrate, latch the
// operand, pulse start, wait for done (with watchdog), return tagged result.
module fpu_operand_sched
    import fpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    fpu_operand_sched_if.sched bus
);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              id_q, id_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wd_q, wd_d;

    logic gnt_idx, gnt_vld;
    logic rdy0, rdy1, start, ovld;

    rr_arbiter_2 u_arb (
        .req0_i    (bus.in0_valid),
        .req1_i    (bus.in1_valid),
        .ptr_i     (rr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        op_d    = op_q;
        res_d   = res_q;
        id_d    = id_q;
        err_d   = err_q;
        wd_d    = wd_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        start   = 1'b0;
        ovld    = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so no handshake is
                // reported that the registers cannot capture.
                if (gnt_vld && rst_n) begin
                    rdy0    = ~gnt_idx;
                    rdy1    = gnt_idx;
                    op_d    = gnt_idx ? bus.in1_data : bus.in0_data;
                    sel_d   = gnt_idx;
                    rr_d    = ~gnt_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A done landing on the timeout cycle still delivers the result.
                if (bus.fpu_done) begin
                    res_d   = bus.fpu_result;
                    id_d    = sel_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = DATA_W'(QNAN);
                    id_d    = sel_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ovld = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            res_q   <= res_d;
            id_q    <= id_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.in0_ready = rdy0;
    assign bus.in1_ready = rdy1;
    assign bus.mux_sel   = sel_q;
    assign bus.op_data   = op_q;
    assign bus.fpu_start = start;
    assign bus.out_valid = ovld;
    assign bus.out_data  = res_q;
    assign bus.out_id    = id_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_operand_sched.sv
// Directed bench for fpu_operand_sched: arbitration, handshake, watchdog,
// spurious done and asynchronous reset behaviour.
module tb_fpu_operand_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_operand_sched_if #(.DATA_W(32)) bus ();

    fpu_operand_sched #(.DATA_W(32), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Simple FPU stand-in: negates the operand, done `lat` cycles after start.
    bit          auto_en = 1'b0;
    int          lat = 2;
    int          auto_cnt = 0;
    logic [31:0] auto_res = '0;
    logic        man_done = 1'b0;
    logic [31:0] man_res = '0;
    int          start_cnt = 0, r0_cnt = 0, both_cnt = 0;

    assign bus.fpu_done   = auto_en ? (auto_cnt == 1) : man_done;
    assign bus.fpu_result = auto_en ? auto_res : man_res;

    always @(posedge clk) begin
        if (bus.fpu_start) begin
            auto_cnt <= lat;
            auto_res <= bus.op_data ^ 32'h8000_0000;
        end else if (auto_cnt != 0) begin
            auto_cnt <= auto_cnt - 1;
        end
        if (bus.fpu_start) start_cnt <= start_cnt + 1;
        if (bus.in0_ready) r0_cnt <= r0_cnt + 1;
        if (bus.in0_ready && bus.in1_ready) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench stuck");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in0_valid = 1'b0; bus.in0_data = '0;
        bus.in1_valid = 1'b0; bus.in1_data = '0;
        bus.out_ready = 1'b0;
        man_done = 1'b0; man_res = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        tick(); tick();
        n_tests++;
        if ({bus.busy, bus.out_valid, bus.fpu_start, bus.mux_sel, bus.in0_ready,
             bus.in1_ready, bus.out_id, bus.out_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {bus.busy, bus.out_valid,
                bus.fpu_start, bus.mux_sel, bus.in0_ready, bus.in1_ready, bus.out_id, bus.out_err});
        end
        n_tests++;
        if (bus.op_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_op_data got=%h exp=00000000", bus.op_data);
        end
        n_tests++;
        if (bus.out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data);
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s_r0, s_st;
        do_reset();
        auto_en = 1'b0;
        s_r0 = r0_cnt; s_st = start_cnt;
        bus.in0_valid = 1'b1; bus.in0_data = 32'h3F80_0000;
        #1;
        n_tests++;
        if (bus.in0_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready got=%b exp=1", bus.in0_ready);
        end
        tick();
        bus.in0_valid = 1'b0;
        n_tests++;
        if (bus.fpu_start !== 1'b1 || bus.mux_sel !== 1'b0 || bus.op_data !== 32'h3F80_0000) begin
            n_fail++;
            $display("FAIL single_issue got=start %b sel %b op %h exp=start 1 sel 0 op 3f800000",
                     bus.fpu_start, bus.mux_sel, bus.op_data);
        end
        tick(); tick(); tick();
        man_done = 1'b1; man_res = 32'h4000_0000;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early_valid got=%b exp=0", bus.out_valid);
        end
        tick();
        man_done = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4000_0000 || bus.out_id !== 1'b0 ||
            bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result got=v %b d %h id %b err %b exp=v 1 d 40000000 id 0 err 0",
                     bus.out_valid, bus.out_data, bus.out_id, bus.out_err);
        end
        n_tests++;
        if (r0_cnt - s_r0 !== 1 || start_cnt - s_st !== 1) begin
            n_fail++;
            $display("FAIL single_pulses got=ready %0d start %0d exp=1 1", r0_cnt - s_r0, start_cnt - s_st);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_drain got=v %b busy %b exp=0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_contention();
        int s_both;
        logic exp_id;
        logic [31:0] exp_d;
        do_reset();
        auto_en = 1'b1; lat = 2;
        s_both = both_cnt;
        bus.out_ready = 1'b1;
        bus.in0_valid = 1'b1; bus.in0_data = 32'h3FC0_0000;
        bus.in1_valid = 1'b1; bus.in1_data = 32'hC020_0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            int c = 0;
            exp_id = 1'(i % 2);
            exp_d  = exp_id ? 32'h4020_0000 : 32'hBFC0_0000;
            while (!(bus.in0_ready || bus.in1_ready) && c < 50) begin tick(); c++; end
            n_tests++;
            if (bus.in1_ready !== exp_id || bus.in0_ready !== !exp_id) begin
                n_fail++;
                $display("FAIL cont_grant[%0d] got=r0 %b r1 %b exp=grant %b", i, bus.in0_ready,
                         bus.in1_ready, exp_id);
            end
            tick();
            n_tests++;
            if (bus.mux_sel !== exp_id) begin
                n_fail++; $display("FAIL cont_sel[%0d] got=%b exp=%b", i, bus.mux_sel, exp_id);
            end
            c = 0;
            while (!bus.out_valid && c < 50) begin tick(); c++; end
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_data !== exp_d) begin
                n_fail++;
                $display("FAIL cont_result[%0d] got=v %b id %b d %h exp=v 1 id %b d %h", i,
                         bus.out_valid, bus.out_id, bus.out_data, exp_id, exp_d);
            end
            tick();
        end
        n_tests++;
        if (both_cnt - s_both !== 0) begin
            n_fail++; $display("FAIL cont_dual_ready got=%0d exp=0", both_cnt - s_both);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        auto_en = 1'b1; lat = 2;
        bus.in1_valid = 1'b1; bus.in1_data = 32'h4049_0FDB;
        #1;
        tick();
        bus.in1_valid = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 32'h3F80_0000;
        while (!bus.out_valid && c < 50) begin tick(); c++; end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hC049_0FDB || bus.out_id !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got=v %b d %h id %b exp=v 1 d c0490fdb id 1", k,
                         bus.out_valid, bus.out_data, bus.out_id);
            end
            n_tests++;
            if (bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_no_grant[%0d] got=r0 %b r1 %b exp=0 0", k, bus.in0_ready, bus.in1_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume got=v %b r0 %b exp=v 0 r0 1", bus.out_valid, bus.in0_ready);
        end
        tick();
        bus.in0_valid = 1'b0;
        n_tests++;
        if (bus.fpu_start !== 1'b1 || bus.mux_sel !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_issue got=start %b sel %b exp=1 0", bus.fpu_start, bus.mux_sel);
        end
        c = 0;
        while (!bus.out_valid && c < 50) begin tick(); c++; end
        bus.out_ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        auto_en = 1'b0;
        bus.in1_valid = 1'b1; bus.in1_data = 32'h3F80_0000;
        #1;
        tick();
        bus.in1_valid = 1'b0;
        n_tests++;
        if (bus.fpu_start !== 1'b1) begin
            n_fail++; $display("FAIL to_issue got=%b exp=1", bus.fpu_start);
        end
        repeat (64) tick();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL to_early got=%b exp=0", bus.out_valid);
        end
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_data !== 32'h7FC0_0000 ||
            bus.out_id !== 1'b1) begin
            n_fail++;
            $display("FAIL to_abort got=v %b err %b d %h id %b exp=v 1 err 1 d 7fc00000 id 1",
                     bus.out_valid, bus.out_err, bus.out_data, bus.out_id);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 32'h4000_0000;
        #1;
        tick();
        bus.in0_valid = 1'b0;
        repeat (64) tick();
        man_done = 1'b1; man_res = 32'h4228_0000;
        tick();
        man_done = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0 || bus.out_data !== 32'h4228_0000 ||
            bus.out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL to_done_wins got=v %b err %b d %h id %b exp=v 1 err 0 d 42280000 id 0",
                     bus.out_valid, bus.out_err, bus.out_data, bus.out_id);
        end
        bus.out_ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        auto_en = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 32'h3F80_0000;
        #1;
        tick();
        bus.in0_valid = 1'b0;
        tick();
        man_done = 1'b1; man_res = 32'h3F00_0000;
        tick();
        man_done = 1'b1; man_res = 32'hDEAD_BEEF;
        tick();
        man_done = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F00_0000 || bus.out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_resp got=v %b d %h err %b exp=v 1 d 3f000000 err 0",
                     bus.out_valid, bus.out_data, bus.out_err);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        man_done = 1'b1; man_res = 32'h1234_5678;
        tick();
        man_done = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h3F00_0000) begin
            n_fail++;
            $display("FAIL spur_idle got=busy %b v %b d %h exp=busy 0 v 0 d 3f000000",
                     bus.busy, bus.out_valid, bus.out_data);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        int c = 0;
        do_reset();
        auto_en = 1'b0;
        bus.in1_valid = 1'b1; bus.in1_data = 32'h4040_0000;
        #1;
        tick();
        bus.in1_valid = 1'b0;
        tick(); tick();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.mux_sel !== 1'b1 || bus.op_data !== 32'h4040_0000) begin
            n_fail++;
            $display("FAIL ar_pre got=busy %b sel %b op %h exp=busy 1 sel 1 op 40400000",
                     bus.busy, bus.mux_sel, bus.op_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.out_valid, bus.fpu_start, bus.mux_sel, bus.out_id, bus.out_err} !== 6'h0 ||
            bus.op_data !== 32'h0 || bus.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_clear got=ctl %b op %h d %h exp=ctl 000000 op 0 d 0",
                     {bus.busy, bus.out_valid, bus.fpu_start, bus.mux_sel, bus.out_id, bus.out_err},
                     bus.op_data, bus.out_data);
        end
        tick();
        rst_n = 1'b1;
        man_done = 1'b1; man_res = 32'h1234_5678;
        tick();
        man_done = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_late_done got=busy %b v %b d %h exp=0 0 00000000",
                     bus.busy, bus.out_valid, bus.out_data);
        end
        bus.in1_valid = 1'b1; bus.in1_data = 32'h3F80_0000;
        #1;
        n_tests++;
        if (bus.in1_ready !== 1'b1 || bus.in0_ready !== 1'b0) begin
            n_fail++; $display("FAIL ar_regrant got=r0 %b r1 %b exp=0 1", bus.in0_ready, bus.in1_ready);
        end
        tick();
        bus.in1_valid = 1'b0;
        tick();
        man_done = 1'b1; man_res = 32'h3F00_0001;
        tick();
        man_done = 1'b0;
        while (!bus.out_valid && c < 20) begin tick(); c++; end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 1'b1 || bus.out_data !== 32'h3F00_0001) begin
            n_fail++;
            $display("FAIL ar_after got=v %b id %b d %h exp=v 1 id 1 d 3f000001",
                     bus.out_valid, bus.out_id, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
